// File: rtl/leaf_slot_scheduler.sv
// leaf_slot_scheduler
// Round-robin arbiter that hands a single shared resource slot to one leaf
// at a time. A holder keeps the slot until it pulses done, drops its request,
// or uses up its hold budget (preemption). Each grant is followed by one
// RELEASE cycle and one IDLE cycle before the next grant can be issued.
//
// Handshake: a leaf owns the slot in every cycle where gnt[i] is high. It
// gives the slot back by presenting done[i]=1 or req[i]=0 at a clock edge.
// After that edge gnt drops. Only the current holder's done bit has any effect.
module leaf_slot_scheduler #(
   parameter int NUM_REQ  = 10,
   parameter int MAX_HOLD = 16,
   parameter int ID_W     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] done,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    gnt_id,
   output logic               preempt,
   output logic               busy,
   output logic [1:0]         o_dbg_state
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT   = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [1:0]         r_state;
   logic [NUM_REQ-1:0] r_gnt;
   logic [ID_W-1:0]    r_gnt_id;
   logic [ID_W-1:0]    r_ptr;
   logic [7:0]         r_hold_cnt;
   logic               r_preempt;

   logic               w_found;
   logic [ID_W-1:0]    w_sel;
   logic [ID_W-1:0]    w_ptr_next;
   logic               w_holder_release;
   logic               w_budget_spent;

   // Rotating-priority search: first requester at or after r_ptr, wrapping at NUM_REQ-1.
   always_comb begin : search
      logic [ID_W:0] v_idx;
      w_found = 1'b0;
      w_sel   = '0;
      v_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         v_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
         if (v_idx >= (ID_W+1)'(NUM_REQ)) begin
            v_idx = v_idx - (ID_W+1)'(NUM_REQ);
         end
         if (!w_found && req[v_idx[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_sel   = v_idx[ID_W-1:0];
         end
      end
   end

   // Holder-specific release terms and the pointer value used after any grant exit.
   always_comb begin
      w_holder_release = done[r_gnt_id] | ~req[r_gnt_id];
      w_budget_spent   = (r_hold_cnt == 8'(MAX_HOLD));
      w_ptr_next       = (r_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : (r_gnt_id + ID_W'(1));
   end

   // Scheduler FSM with grant, pointer, hold counter and preempt pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_gnt      <= '0;
         r_gnt_id   <= '0;
         r_ptr      <= '0;
         r_hold_cnt <= '0;
         r_preempt  <= 1'b0;
      end else begin
         r_preempt <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_gnt      <= ONE_HOT_0 << w_sel;
                  r_gnt_id   <= w_sel;
                  r_hold_cnt <= 8'd1;
                  r_state    <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (w_holder_release || w_budget_spent) begin
                  // A holder release on the budget edge is a normal release, not a preemption.
                  r_preempt <= ~w_holder_release;
                  r_gnt     <= '0;
                  r_gnt_id  <= '0;
                  r_ptr     <= w_ptr_next;
                  r_state   <= ST_RELEASE;
               end else if (r_hold_cnt != 8'hFF) begin
                  r_hold_cnt <= r_hold_cnt + 8'd1;
               end
            end
            ST_RELEASE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_gnt    <= '0;
               r_gnt_id <= '0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs come straight from registers; the grant is valid exactly in GRANT.
   always_comb begin
      gnt         = r_gnt;
      gnt_id      = r_gnt_id;
      gnt_valid   = (r_state == ST_GRANT);
      busy        = (r_state != ST_IDLE);
      preempt     = r_preempt;
      o_dbg_state = r_state;
   end

endmodule

// File: doc/leaf_slot_scheduler.md
# leaf_slot_scheduler

Round-robin scheduler that shares one common resource slot among the NUM_REQ leaf instances of a generated subtree. Each leaf raises a request and the scheduler grants exactly one holder at a time. The holder keeps the slot until it signals done, withdraws its request, or exceeds a hold budget, in which case it is preempted. The block sits in the parent module next to the ten leaf instances and drives their one-hot grant lines.

## Interface
- NUM_REQ, 10, number of requesters (2..16)
- MAX_HOLD, 16, max cycles a holder may keep the grant (1..255)
- ID_W, 4, width of grant index; must satisfy 2**ID_W >= NUM_REQ

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  per-leaf request level
- done  in  NUM_REQ  per-leaf release pulse; only the current holder's bit is honoured
- gnt  out  NUM_REQ  one-hot grant, registered
- gnt_valid  out  1  high while any grant is held
- gnt_id  out  ID_W  index of current holder; 0 when gnt_valid is low
- preempt  out  1  one-cycle pulse when a holder is revoked on budget expiry
- busy  out  1  high in GRANT and RELEASE states

## Operation
- Three-state FSM: IDLE, GRANT, RELEASE. Reset state is IDLE.
- Round-robin pointer ptr (ID_W bits) resets to 0.
- IDLE: search req starting at ptr, ascending with wrap from NUM_REQ-1 to 0. On the first set bit i:
  - load gnt = one-hot(i) and gnt_id = i;
  - set hold_cnt = 1 and go to GRANT.
- IDLE with no request: stay in IDLE.
- GRANT release conditions, evaluated in priority order:
  - done[i] = 1 or req[i] = 0: normal release, go to RELEASE.
  - otherwise, hold_cnt == MAX_HOLD: preempt = 1 for that cycle, go to RELEASE.
  - otherwise: hold_cnt increments and the FSM stays in GRANT.
- On any exit from GRANT, ptr = i + 1, wrapping to 0 when i = NUM_REQ-1.
- RELEASE: lasts exactly one cycle with gnt = 0, then returns to IDLE.
- done bits of non-holders are ignored in all states. All done bits are ignored in IDLE and RELEASE.
- Request bits at indices >= NUM_REQ do not exist. ptr never exceeds NUM_REQ-1.
- hold_cnt is 8 bits and saturates; it is compared only against MAX_HOLD.

## Timing
- Reset values: gnt = 0, gnt_valid = 0, gnt_id = 0, preempt = 0, busy = 0, ptr = 0, FSM in IDLE.
- Asserting rst mid-grant clears all outputs immediately (asynchronously). No preempt pulse is generated on reset.
- Grant latency: req[i] seen high at clock edge N in IDLE gives gnt[i] high after edge N, i.e. in cycle N+1.
- Normal release: done[i] sampled at edge M clears gnt after edge M. RELEASE occupies cycle M+1, IDLE is entered at M+2, and the earliest next grant appears at M+3.
- Minimum dead time between consecutive grants: 2 cycles.
- Preemption: a holder with req held high and done low loses gnt after exactly MAX_HOLD cycles of gnt_valid = 1. preempt is high in the first RELEASE cycle.
- done and budget expiry on the same edge: counts as a normal release; preempt stays 0.
- gnt, gnt_valid, gnt_id and busy are all registered; there are no combinational paths from inputs to outputs.
- gnt_valid is identical to the OR of gnt, and gnt_id always matches the set bit of gnt.

## Test plan
- Reset, then req=0x001 held and done pulsed on the 3rd grant cycle. Required: gnt=0x001 one cycle after req, gnt_id=0, gnt=0 in the RELEASE cycle, re-grant to leaf 0 two cycles later.
- req=0x3FF held, each holder pulses done on its first grant cycle. Required: grants go to ids 0,1,2,…,9,0 in order, wrapping after 9, with 2 idle cycles between grants.
- req=0x020 held and done never asserted, MAX_HOLD=16. Required: gnt=0x020 for exactly 16 cycles, then preempt=1 for 1 cycle, then re-grant to id 5.
- ptr=3 after a release of id 2, with req=0x205. Required: next grant goes to id 9, then id 0 (wrap), then id 2.
- During a grant to id 4, pulse done[7] and done[0]. Required: no release. Later, done[4] asserted on the same edge as hold_cnt reaches MAX_HOLD. Required: release with preempt=0.
- Assert rst while gnt=0x040. Required: gnt=0, busy=0, gnt_id=0 immediately. After rst drops with req=0x040, re-grant goes to id 6 with search starting at ptr=0.
